gpu_op_arbiter: RTL and testbench

Shares the single GPU operation FIFO write port among `REQUESTERS` independent op producers, such as the game-logic FSM and a score/overlay drawer. The block grants requesters round-robin, writes one `gpu_op_t` per grant, and tracks per-frame completion through a "last op" flag. It raises `frame_done` once every requester has finished its frame, and re-arms on `swap`. It sits between the producers and the GPU op FIFO, in the slot the CPU's own `op`/`op_wr_en`/`op_full` handshake occupied.

---
 rtl/gpu_op_arbiter.sv | 128 ++++++++++++
 tb/tb_gpu_op_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_op_arbiter.sv
// Round-robin arbiter sharing the GPU op FIFO write port among several op producers,
// with a per-frame completion barrier released by the display swap. OP_W is the gpu_op_t width.
module gpu_op_arbiter #(
  parameter int REQUESTERS = 2,
  parameter int OP_W       = 32,
  parameter int GRANT_W    = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic [REQUESTERS-1:0]      req_valid,
  input  logic [REQUESTERS*OP_W-1:0] req_op,
  input  logic [REQUESTERS-1:0]      req_last,
  output logic [REQUESTERS-1:0]      req_ack,
  output logic [OP_W-1:0]            op,
  output logic                       op_wr_en,
  input  logic                       op_full,
  input  logic                       swap,
  output logic                       frame_done,
  output logic [GRANT_W-1:0]         grant_idx
);

  typedef enum logic {IDLE, GAP} state_t;

  state_t                  state, state_n;
  logic [GRANT_W-1:0]      last_grant, last_grant_n;
  logic [REQUESTERS-1:0]   done_mask, done_mask_n;
  logic [REQUESTERS-1:0]   req_ack_n;
  logic [OP_W-1:0]         op_n;
  logic                    op_wr_en_n;
  logic                    frame_done_n;
  logic [GRANT_W-1:0]      grant_idx_n;

  logic [REQUESTERS-1:0]   eligible;
  logic [REQUESTERS-1:0]   sel_oh;
  logic [GRANT_W-1:0]      sel_idx;
  logic                    found;
  logic [OP_W-1:0]         sel_op;

  assign eligible = req_valid & ~done_mask;

  // Two passes: indices above the last grant first, then wrap around to the rest.
  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (!found && eligible[i] && (i > int'(last_grant))) begin
        sel_oh[i] = 1'b1;
        sel_idx   = GRANT_W'(i);
        found     = 1'b1;
      end
    end
    for (int i = 0; i < REQUESTERS; i++) begin
      if (!found && eligible[i] && (i <= int'(last_grant))) begin
        sel_oh[i] = 1'b1;
        sel_idx   = GRANT_W'(i);
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    sel_op = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (sel_oh[i]) sel_op = req_op[i*OP_W +: OP_W];
    end
  end

  // Write strobe and acks default low so they never outlive one edge, even with ce low.
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    done_mask_n  = done_mask;
    req_ack_n    = '0;
    op_n         = op;
    op_wr_en_n   = 1'b0;
    frame_done_n = frame_done;
    grant_idx_n  = grant_idx;
    if (ce) begin
      case (state)
        IDLE: begin
          if (!op_full && !frame_done && found) begin
            op_n         = sel_op;
            op_wr_en_n   = 1'b1;
            req_ack_n    = sel_oh;
            grant_idx_n  = sel_idx;
            last_grant_n = sel_idx;
            done_mask_n  = done_mask | (sel_oh & req_last);
            state_n      = GAP;
          end
        end
        GAP:     state_n = IDLE;
        default: state_n = IDLE;
      endcase
      // A grant cannot coincide with an accepted swap: grants are blocked while frame_done is high.
      if (frame_done && swap) begin
        done_mask_n  = '0;
        frame_done_n = 1'b0;
      end else if (&done_mask) begin
        frame_done_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GRANT_W'(REQUESTERS - 1);
      done_mask  <= '0;
      req_ack    <= '0;
      op         <= '0;
      op_wr_en   <= 1'b0;
      frame_done <= 1'b0;
      grant_idx  <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      done_mask  <= done_mask_n;
      req_ack    <= req_ack_n;
      op         <= op_n;
      op_wr_en   <= op_wr_en_n;
      frame_done <= frame_done_n;
      grant_idx  <= grant_idx_n;
    end
  end

endmodule

// File: tb/tb_gpu_op_arbiter.sv
// Bench for gpu_op_arbiter: a cycle model derived from the arbitration rules is compared
// every cycle, and directed scenarios pin the model with hand-computed literal expectations.
module tb_gpu_op_arbiter;

  localparam int R  = 2;
  localparam int W  = 16;
  localparam int GW = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ce = 1'b1;
  logic [R-1:0]  req_valid = '0;
  logic [R-1:0]  req_last = '0;
  logic [W-1:0]  op0 = 16'hA001;
  logic [W-1:0]  op1 = 16'hB001;
  logic [R*W-1:0] req_op;
  logic          op_full = 1'b0;
  logic          swap = 1'b0;
  logic [R-1:0]  req_ack;
  logic [W-1:0]  op;
  logic          op_wr_en;
  logic          frame_done;
  logic [GW-1:0] grant_idx;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  assign req_op = {op1, op0};

  gpu_op_arbiter #(.REQUESTERS(R), .OP_W(W), .GRANT_W(GW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_last   (req_last),
    .req_ack    (req_ack),
    .op         (op),
    .op_wr_en   (op_wr_en),
    .op_full    (op_full),
    .swap       (swap),
    .frame_done (frame_done),
    .grant_idx  (grant_idx)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge and are held through the next rising edge.
  task automatic applyStimulus(input logic [R-1:0] v, input logic [R-1:0] l,
                               input logic full, input logic sw, input logic cen);
    req_valid = v;
    req_last  = l;
    op_full   = full;
    swap      = sw;
    ce        = cen;
    @(negedge clk);
  endtask

  // Model: one write per grant, then a mandatory idle cycle; rotation by modular distance.
  logic [W-1:0] m_op = '0;
  logic         m_wr = 1'b0;
  logic [R-1:0] m_ack = '0;
  int           m_gidx = 0;
  int           m_last = R - 1;
  logic [R-1:0] m_done = '0;
  logic         m_fd = 1'b0;
  logic         m_gap = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_op   <= '0;
      m_wr   <= 1'b0;
      m_ack  <= '0;
      m_gidx <= 0;
      m_last <= R - 1;
      m_done <= '0;
      m_fd   <= 1'b0;
      m_gap  <= 1'b0;
    end else begin : mdl
      bit           fnd;
      int           pick;
      logic [R-1:0] nd;
      fnd  = 1'b0;
      pick = 0;
      nd   = m_done;
      m_wr  <= 1'b0;
      m_ack <= '0;
      if (ce) begin
        if (m_gap) begin
          m_gap <= 1'b0;
        end else if (!op_full && !m_fd) begin
          for (int k = 1; k <= R; k++) begin
            int idx;
            idx = (m_last + k) % R;
            if (!fnd && req_valid[idx] && !m_done[idx]) begin
              fnd  = 1'b1;
              pick = idx;
            end
          end
          if (fnd) begin
            m_op   <= (pick == 0) ? op0 : op1;
            m_wr   <= 1'b1;
            m_ack  <= R'(1) << pick;
            m_gidx <= pick;
            m_last <= pick;
            if (req_last[pick]) nd[pick] = 1'b1;
            m_gap  <= 1'b1;
          end
        end
        if (swap && m_fd) begin
          nd = '0;
          m_fd <= 1'b0;
        end else if ($countones(m_done) == R) begin
          m_fd <= 1'b1;
        end
        m_done <= nd;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checkOutput("cmp_wr_en", 32'(op_wr_en), 32'(m_wr));
      checkOutput("cmp_ack", 32'(req_ack), 32'(m_ack));
      checkOutput("cmp_grant_idx", 32'(grant_idx), 32'(m_gidx));
      checkOutput("cmp_frame_done", 32'(frame_done), 32'(m_fd));
      checkOutput("cmp_op", 32'(op), 32'(m_op));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int prev;
    int ngr;
    int wrs;
    int s0;
    int s1;
    int acks;
    int fifth;

    repeat (2) @(negedge clk);
    checkOutput("rst_wr_en", 32'(op_wr_en), 32'd0);
    checkOutput("rst_ack", 32'(req_ack), 32'd0);
    checkOutput("rst_grant_idx", 32'(grant_idx), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_op", 32'(op), 32'd0);
    rst = 1'b1;
    started = 1'b1;

    // First grant after reset goes to requester 0.
    applyStimulus(2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("first_wr_en", 32'(op_wr_en), 32'd1);
    checkOutput("first_ack", 32'(req_ack), 32'h1);
    checkOutput("first_grant_idx", 32'(grant_idx), 32'd0);
    checkOutput("first_op", 32'(op), 32'hA001);

    // Fairness: alternate grants, pulses two cycles apart.
    prev = 0;
    ngr  = 0;
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
      if (op_wr_en) begin
        checkOutput("fair_idx", 32'(grant_idx), (ngr % 2 == 0) ? 32'd1 : 32'd0);
        checkOutput("fair_spacing", 32'(c - prev), 32'd2);
        prev = c;
        ngr++;
      end
    end
    checkOutput("fair_count", 32'(ngr), 32'd5);

    // Backpressure: no write while full, then exactly one write of requester 1.
    wrs = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(2'b10, 2'b00, 1'b1, 1'b0, 1'b1);
      if (op_wr_en) wrs++;
    end
    checkOutput("full_no_write", 32'(wrs), 32'd0);
    op1 = 16'hBEEF;
    applyStimulus(2'b10, 2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("release_wr_en", 32'(op_wr_en), 32'd1);
    checkOutput("release_op", 32'(op), 32'hBEEF);
    checkOutput("release_ack", 32'(req_ack), 32'h2);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

    // Frame barrier: r0 sends 3 ops, r1 sends 2; stray swaps while frame_done is low.
    s0 = 0;
    s1 = 0;
    acks = 0;
    fifth = -1;
    for (int c = 0; c < 30 && fifth < 0; c++) begin
      op0 = 16'hC000 + W'(s0);
      op1 = 16'hD000 + W'(s1);
      applyStimulus({s1 < 2, s0 < 3}, {s1 == 1, s0 == 2}, 1'b0, (c == 0) || (acks == 4), 1'b1);
      if (req_ack[0]) s0++;
      if (req_ack[1]) s1++;
      if (req_ack != '0) acks++;
      if (acks == 5) begin
        fifth = c;
        checkOutput("fd_low_at_final_ack", 32'(frame_done), 32'd0);
        checkOutput("final_ack_is_r0", 32'(req_ack), 32'h1);
        checkOutput("final_ack_op", 32'(op), 32'hC002);
      end
    end
    checkOutput("barrier_acks", 32'(acks), 32'd5);
    checkOutput("barrier_final_cycle", 32'(fifth), 32'd8);
    applyStimulus(2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("fd_high_after_final", 32'(frame_done), 32'd1);
    wrs = 0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
      if (op_wr_en) wrs++;
    end
    checkOutput("barrier_no_grant", 32'(wrs), 32'd0);
    checkOutput("fd_held", 32'(frame_done), 32'd1);

    // Accepted swap re-arms; grants resume at requester 1 (last grant was r0).
    op0 = 16'h1111;
    op1 = 16'h2222;
    applyStimulus(2'b11, 2'b00, 1'b0, 1'b1, 1'b1);
    checkOutput("swap_fd_clear", 32'(frame_done), 32'd0);
    checkOutput("swap_no_write", 32'(op_wr_en), 32'd0);
    applyStimulus(2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("resume_wr_en", 32'(op_wr_en), 32'd1);
    checkOutput("resume_idx", 32'(grant_idx), 32'd1);
    checkOutput("resume_op", 32'(op), 32'h2222);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

    // ce low right after a grant: still a single write pulse.
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("ce_grant_wr_en", 32'(op_wr_en), 32'd1);
    wrs = 0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
      if (op_wr_en) wrs++;
    end
    checkOutput("ce_single_pulse", 32'(wrs), 32'd0);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

    // Reset during GAP after marking r1 done; mask must come back clear.
    applyStimulus(2'b11, 2'b10, 1'b0, 1'b0, 1'b1);
    checkOutput("pre_rst_wr_en", 32'(op_wr_en), 32'd1);
    checkOutput("pre_rst_idx", 32'(grant_idx), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("midgap_rst_wr_en", 32'(op_wr_en), 32'd0);
    checkOutput("midgap_rst_ack", 32'(req_ack), 32'd0);
    checkOutput("midgap_rst_idx", 32'(grant_idx), 32'd0);
    checkOutput("midgap_rst_op", 32'(op), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(2'b10, 2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("mask_cleared_wr_en", 32'(op_wr_en), 32'd1);
    checkOutput("mask_cleared_ack", 32'(req_ack), 32'h2);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
